seq_pattern_tx: RTL and testbench
=================================

// Module: seq_pattern_tx
// PURPOSE
//  Serial bit-pattern transmitter; the sending end for the Moore sequence_detector blocks.
//  Captures a pattern of up to PAT_W bits on a start pulse and shifts it out on seq_out, MSB first, one bit per clock.
//  The pattern is sent (repeat_cnt+1) times, with an optional idle gap between copies.
//  Used as the stimulus source that drives seq_in of the detectors in system-level benches and self-test paths.
// PARAMETERS
//  PAT_W  4  maximum pattern length in bits
//  LEN_W  3  width of pat_len; must satisfy 2**LEN_W > PAT_W
//  REP_W  4  width of repeat_cnt
//  GAP_W  3  width of gap_cycles
// PORTS
//  clock       in   1      single clock; all logic on the rising edge
//  reset_n     in   1      asynchronous, active-low reset
//  start       in   1      request; sampled only in IDLE
//  pattern     in   PAT_W  bits to send; the valid bits are pattern[pat_len-1:0]
//  pat_len     in   LEN_W  number of bits; 0 or >PAT_W is treated as PAT_W
//  repeat_cnt  in   REP_W  extra copies; total copies = repeat_cnt+1
//  gap_cycles  in   GAP_W  idle cycles inserted between copies (0 = back-to-back)
//  seq_out     out  1      serial data, registered
//  seq_valid   out  1      high while seq_out carries a pattern bit
//  busy        out  1      high from start acceptance until the done cycle, inclusive
//  done        out  1      one-cycle pulse after the last bit of the last copy
// BEHAVIOUR
//  Reset (async assert, sync release): state=IDLE; seq_out, seq_valid, busy and done all 0; internal registers cleared.
//  States: IDLE -> SHIFT -> (GAP -> SHIFT)* -> DONE -> IDLE. All outputs are registered.
//  IDLE:
//   - On start=1 at edge k: latch pattern, effective length L, repeat_cnt and gap_cycles.
//   - Load the shift register left-aligned: pattern << (PAT_W-L).
//   - Go to SHIFT. The first bit pattern[L-1] appears on seq_out after edge k.
//  SHIFT:
//   - seq_valid=1; one bit per cycle, so bits L-1..0 occupy cycles k+1..k+L.
//   - The bit counter counts L down to 1.
//   - After the last bit, copies remaining and gap>0: go to GAP.
//   - Copies remaining and gap=0: reload the latched pattern and continue SHIFT with no bubble.
//   - No copies remaining: go to DONE.
//  GAP: seq_out=0, seq_valid=0 for exactly gap_cycles cycles, then reload the pattern and return to SHIFT.
//  DONE: done=1 and busy=1 for one cycle; seq_valid=0; then IDLE. The earliest new start is accepted in the first IDLE cycle.
//  Latency: start accepted to first bit is 1 cycle.
//   Total busy cycles = (R+1)*L + R*gap + 1, where R = repeat_cnt.
//  start outside IDLE is ignored; it is neither queued nor allowed to alter the latched inputs.
//   Input changes after acceptance have no effect.
//  seq_out=0 whenever seq_valid=0.
//  Counter limits: repeat_cnt=2**REP_W-1 and gap_cycles=2**GAP_W-1 must work without wrap errors.
//   The repeat counter decrements to 0 and never underflows.
//  reset_n low mid-operation aborts immediately: outputs go to 0 asynchronously and no done pulse is issued.
// STRUCTURE
//  Shared include seq_defs.vh:
//   - state encodings (IDLE=0, SHIFT=1, GAP=2, DONE=3; 2-bit)
//   - default widths, also used by the detector benches
//  One sub-module, seq_piso: parallel-in serial-out shift register with load, shift enable and async active-low clear.
//  Top level holds the FSM plus the bit, repeat and gap counters.
// TESTING
//  1. pattern=4'b1011, pat_len=4, rep=0, gap=0, start at cycle 0
//     -> seq_out 1,0,1,1 with valid in cycles 1-4; done in cycle 5; busy in cycles 1-5.
//     A sequence_detector(1011) fed from seq_out raises det_o.
//  2. pattern=4'b0101, pat_len=3, rep=2, gap=0
//     -> 9 contiguous valid bits 101101101; exactly one done pulse, in cycle 10.
//  3. pattern=4'b0101, pat_len=3, rep=1, gap=2 -> valid bits 101, then 2 cycles with seq_valid=0 and seq_out=0, then 101; done in cycle 9.
//  4. start pulsed again in cycle 2 of scenario 1 with pattern=4'hF -> ignored; output still 1011; busy stays high.
//  5. reset_n low in cycle 3 of scenario 2 -> all outputs 0 the same cycle; no done.
//     After release, a start with 4'b1011 transmits correctly.
//  6. pat_len=0 with pattern=4'b1001 -> treated as 4 bits: 1,0,0,1.
//     Also run rep=15, gap=7, L=4 -> busy for 16*4+15*7+1 = 170 cycles.

Source files
------------

// File: rtl/seq_pattern_tx_pkg.sv
// Shared definitions for the serial pattern transmitter and its companion benches:
// FSM state encoding, default widths and the effective-length rule.
package seq_pattern_tx_pkg;

    localparam int unsigned DEF_PAT_W = 4;
    localparam int unsigned DEF_LEN_W = 3;
    localparam int unsigned DEF_REP_W = 4;
    localparam int unsigned DEF_GAP_W = 3;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        GAP   = 2'd2,
        DONE  = 2'd3
    } tx_state_t;

    // A length of 0, or one larger than the pattern register, means "use the full register".
    function automatic int unsigned effective_len(input int unsigned len, input int unsigned pat_w);
        return ((len == 0) || (len > pat_w)) ? pat_w : len;
    endfunction

endpackage

// File: rtl/seq_pattern_tx_piso.sv
// Parallel-in serial-out shift register, MSB first, with load, shift enable and
// asynchronous active-low clear. msb_next exposes the bit that will sit in the MSB
// after the coming edge so the caller can register it as its serial output.
module seq_piso
    import seq_pattern_tx_pkg::*;
#(
    parameter int unsigned W = DEF_PAT_W
) (
    input  logic         clock,
    input  logic         clear_n,
    input  logic         load,
    input  logic         shift_en,
    input  logic [W-1:0] load_data,
    output logic         msb_next
);

    logic [W-1:0] data_q;
    logic [W-1:0] data_d;

    // Next shift-register contents: load has priority over shifting.
    always_comb begin
        data_d = data_q;
        if (load) begin
            data_d = load_data;
        end else if (shift_en) begin
            data_d = data_q << 1;
        end
        msb_next = data_d[W-1];
    end

    // Shift-register storage.
    always_ff @(posedge clock or negedge clear_n) begin
        if (!clear_n) begin
            data_q <= '0;
        end else begin
            data_q <= data_d;
        end
    end

endmodule

// File: rtl/seq_pattern_tx.sv
// Serial bit-pattern transmitter. Captures up to PAT_W bits on a start pulse and
// sends them MSB first on seq_out, repeat_cnt+1 times, with gap_cycles idle
// cycles between copies. All outputs are registered from the next-state values.
module seq_pattern_tx
    import seq_pattern_tx_pkg::*;
#(
    parameter int unsigned PAT_W = DEF_PAT_W,
    parameter int unsigned LEN_W = DEF_LEN_W,
    parameter int unsigned REP_W = DEF_REP_W,
    parameter int unsigned GAP_W = DEF_GAP_W
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic             start,
    input  logic [PAT_W-1:0] pattern,
    input  logic [LEN_W-1:0] pat_len,
    input  logic [REP_W-1:0] repeat_cnt,
    input  logic [GAP_W-1:0] gap_cycles,
    output logic             seq_out,
    output logic             seq_valid,
    output logic             busy,
    output logic             done
);

    tx_state_t        state;
    tx_state_t        state_n;

    logic [PAT_W-1:0] pat_q;
    logic [LEN_W-1:0] len_q;
    logic [REP_W-1:0] rep_q;
    logic [GAP_W-1:0] gap_q;
    logic [LEN_W-1:0] bit_cnt;
    logic [GAP_W-1:0] gap_cnt;

    logic [LEN_W-1:0] len_in;
    logic             last_bit;
    logic             more_copies;
    logic             gap_last;

    logic             accept;
    logic             reload;
    logic             shift_en;
    logic             piso_load;
    logic [PAT_W-1:0] load_data;
    logic             piso_msb_next;

    logic             seq_out_d;
    logic             seq_valid_d;
    logic             busy_d;
    logic             done_d;

    assign len_in      = LEN_W'(effective_len(32'(pat_len), PAT_W));
    assign last_bit    = (bit_cnt == LEN_W'(1));
    assign more_copies = (rep_q != '0);
    assign gap_last    = (gap_cnt == GAP_W'(1));

    // State register.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state <= IDLE;
        end else begin
            state <= state_n;
        end
    end

    // Next-state logic.
    always_comb begin
        state_n = state;
        case (state)
            IDLE: begin
                if (start) begin
                    state_n = SHIFT;
                end
            end
            SHIFT: begin
                if (last_bit) begin
                    if (!more_copies) begin
                        state_n = DONE;
                    end else if (gap_q != '0) begin
                        state_n = GAP;
                    end else begin
                        state_n = SHIFT;
                    end
                end
            end
            GAP: begin
                if (gap_last) begin
                    state_n = SHIFT;
                end
            end
            DONE: begin
                state_n = IDLE;
            end
            default: begin
                state_n = IDLE;
            end
        endcase
    end

    // Datapath controls and next values of the registered outputs.
    always_comb begin
        accept    = (state == IDLE) && start;
        reload    = ((state == SHIFT) && last_bit && more_copies && (gap_q == '0)) ||
                    ((state == GAP) && gap_last);
        shift_en  = (state == SHIFT) && !last_bit;
        piso_load = accept || reload;
        load_data = accept ? (pattern << (PAT_W - 32'(len_in)))
                           : (pat_q << (PAT_W - 32'(len_q)));

        seq_valid_d = (state_n == SHIFT);
        seq_out_d   = seq_valid_d && piso_msb_next;
        busy_d      = (state_n != IDLE);
        done_d      = (state_n == DONE);
    end

    // Latched request, bit/repeat/gap counters and output registers.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            pat_q     <= '0;
            len_q     <= '0;
            rep_q     <= '0;
            gap_q     <= '0;
            bit_cnt   <= '0;
            gap_cnt   <= '0;
            seq_out   <= 1'b0;
            seq_valid <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
        end else begin
            seq_out   <= seq_out_d;
            seq_valid <= seq_valid_d;
            busy      <= busy_d;
            done      <= done_d;

            if (accept) begin
                pat_q   <= pattern;
                len_q   <= len_in;
                rep_q   <= repeat_cnt;
                gap_q   <= gap_cycles;
                bit_cnt <= len_in;
            end else begin
                if (reload) begin
                    bit_cnt <= len_q;
                end else if (shift_en) begin
                    bit_cnt <= bit_cnt - 1'b1;
                end

                if ((state == SHIFT) && last_bit && more_copies) begin
                    rep_q <= rep_q - 1'b1;
                end

                if ((state == SHIFT) && last_bit && more_copies && (gap_q != '0)) begin
                    gap_cnt <= gap_q;
                end else if ((state == GAP) && !gap_last) begin
                    gap_cnt <= gap_cnt - 1'b1;
                end
            end
        end
    end

    seq_piso #(
        .W(PAT_W)
    ) u_piso (
        .clock     (clock),
        .clear_n   (reset_n),
        .load      (piso_load),
        .shift_en  (shift_en),
        .load_data (load_data),
        .msb_next  (piso_msb_next)
    );

endmodule

// File: tb/tb_seq_pattern_tx.sv
// Scoreboard bench for seq_pattern_tx: each request pushes the expected per-cycle
// output stream (built from the transmit rules) into a queue; a monitor on the
// falling edge pops and compares whenever the DUT is busy.
module tb_seq_pattern_tx;

    localparam int unsigned PAT_W = 4;
    localparam int unsigned LEN_W = 3;
    localparam int unsigned REP_W = 4;
    localparam int unsigned GAP_W = 3;

    logic             clock;
    logic             reset_n;
    logic             start;
    logic [PAT_W-1:0] pattern;
    logic [LEN_W-1:0] pat_len;
    logic [REP_W-1:0] repeat_cnt;
    logic [GAP_W-1:0] gap_cycles;
    logic             seq_out;
    logic             seq_valid;
    logic             busy;
    logic             done;

    typedef struct packed {
        logic valid;
        logic bit_v;
        logic done;
    } cyc_t;

    cyc_t        exp_q[$];
    int unsigned exp_busy_q[$];
    int unsigned busy_run;
    int unsigned checks;
    int unsigned passed;

    seq_pattern_tx #(
        .PAT_W(PAT_W),
        .LEN_W(LEN_W),
        .REP_W(REP_W),
        .GAP_W(GAP_W)
    ) dut (
        .clock      (clock),
        .reset_n    (reset_n),
        .start      (start),
        .pattern    (pattern),
        .pat_len    (pat_len),
        .repeat_cnt (repeat_cnt),
        .gap_cycles (gap_cycles),
        .seq_out    (seq_out),
        .seq_valid  (seq_valid),
        .busy       (busy),
        .done       (done)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act === req) begin
            passed++;
        end else begin
            $display("FAIL %s: actual=%0h required=%0h at %0t", name, act, req, $time);
        end
    endtask

    // Reference model: expected output of every busy cycle of one request.
    task automatic push_txn(input logic [3:0] p, input int unsigned len, input int unsigned rep,
                            input int unsigned gap);
        int unsigned l;
        l = ((len == 0) || (len > PAT_W)) ? PAT_W : len;
        for (int unsigned c = 0; c <= rep; c++) begin
            for (int i = int'(l) - 1; i >= 0; i--) begin
                exp_q.push_back('{valid: 1'b1, bit_v: p[i], done: 1'b0});
            end
            if (c < rep) begin
                for (int unsigned g = 0; g < gap; g++) begin
                    exp_q.push_back('{valid: 1'b0, bit_v: 1'b0, done: 1'b0});
                end
            end
        end
        exp_q.push_back('{valid: 1'b0, bit_v: 1'b0, done: 1'b1});
        exp_busy_q.push_back((rep + 1) * l + rep * gap + 1);
    endtask

    // Monitor: compare the DUT against the scoreboard away from the active edge.
    always @(negedge clock) begin
        if (reset_n) begin
            if (busy) begin
                busy_run++;
                if (exp_q.size() == 0) begin
                    check("busy_unexpected", 32'(exp_q.size()), 32'd1);
                end else begin
                    cyc_t e;
                    e = exp_q.pop_front();
                    check("cycle_valid_out_done", 32'({seq_valid, seq_out, done}),
                          32'({e.valid, e.bit_v, e.done}));
                end
                if (done) begin
                    if (exp_busy_q.size() == 0) begin
                        check("done_unexpected", 32'(exp_busy_q.size()), 32'd1);
                    end else begin
                        check("busy_cycles", busy_run, exp_busy_q.pop_front());
                    end
                    busy_run = 0;
                end
            end else begin
                check("idle_outputs", 32'({seq_valid, seq_out, done}), 32'd0);
            end
        end
    end

    task automatic wait_drain();
        for (int n = 0; n < 400; n++) begin
            if (exp_q.size() == 0) break;
            @(posedge clock);
            #1;
        end
        check("drain", 32'(exp_q.size()), 32'd0);
        exp_q.delete();
        exp_busy_q.delete();
    endtask

    // Issue one request (called #1 after a rising edge); optionally disturb inputs while busy.
    task automatic send(input logic [3:0] p, input int unsigned len, input int unsigned rep,
                        input int unsigned gap, input bit noise);
        pattern    = p;
        pat_len    = LEN_W'(len);
        repeat_cnt = REP_W'(rep);
        gap_cycles = GAP_W'(gap);
        start      = 1'b1;
        push_txn(p, len, rep, gap);
        @(posedge clock);
        #1;
        start = 1'b0;
        if (noise) begin
            for (int n = 0; n < 400; n++) begin
                if (!busy) begin
                    start = 1'b0;
                    break;
                end
                pattern    = PAT_W'($urandom);
                pat_len    = LEN_W'($urandom);
                repeat_cnt = REP_W'($urandom);
                gap_cycles = GAP_W'($urandom);
                start      = 1'($urandom_range(0, 1));
                @(posedge clock);
                #1;
            end
            start = 1'b0;
        end
        wait_drain();
    endtask

    initial begin
        checks     = 0;
        passed     = 0;
        busy_run   = 0;
        reset_n    = 1'b0;
        start      = 1'b0;
        pattern    = '0;
        pat_len    = '0;
        repeat_cnt = '0;
        gap_cycles = '0;

        repeat (3) @(posedge clock);
        #1;
        check("reset_seq_out", 32'(seq_out), 32'd0);
        check("reset_seq_valid", 32'(seq_valid), 32'd0);
        check("reset_busy", 32'(busy), 32'd0);
        check("reset_done", 32'(done), 32'd0);
        reset_n = 1'b1;
        @(posedge clock);
        #1;

        // 1011 once; 3-bit 101 three times back-to-back; 101 twice with a 2-cycle gap
        send(4'b1011, 4, 0, 0, 1'b0);
        send(4'b0101, 3, 2, 0, 1'b0);
        send(4'b0101, 3, 1, 2, 1'b0);

        // Second start while busy, with a different pattern, must be ignored
        pattern = 4'b1011; pat_len = 3'd4; repeat_cnt = '0; gap_cycles = '0;
        start = 1'b1;
        push_txn(4'b1011, 4, 0, 0);
        @(posedge clock); #1;
        start = 1'b0;
        @(posedge clock); #1;
        pattern = 4'hF; start = 1'b1;
        @(posedge clock); #1;
        start = 1'b0;
        wait_drain();

        // Zero length means full width; then the repeat/gap counter limits
        send(4'b1001, 0, 0, 0, 1'b0);
        send(4'b1101, 4, 15, 7, 1'b0);
        send(4'b0110, 7, 1, 1, 1'b0);

        // Reset mid-transmission aborts without a done pulse
        pattern = 4'b0101; pat_len = 3'd3; repeat_cnt = 4'd2; gap_cycles = '0;
        start = 1'b1;
        push_txn(4'b0101, 3, 2, 0);
        @(posedge clock); #1;
        start = 1'b0;
        repeat (2) @(posedge clock);
        #1;
        check("pre_abort_busy", 32'(busy), 32'd1);
        reset_n = 1'b0;
        #1;
        check("abort_seq_out", 32'(seq_out), 32'd0);
        check("abort_seq_valid", 32'(seq_valid), 32'd0);
        check("abort_busy", 32'(busy), 32'd0);
        check("abort_done", 32'(done), 32'd0);
        exp_q.delete();
        exp_busy_q.delete();
        busy_run = 0;
        repeat (2) @(posedge clock);
        #1;
        reset_n = 1'b1;
        @(posedge clock); #1;
        send(4'b1011, 4, 0, 0, 1'b0);

        // Randomised requests with input noise and ignored starts while busy
        for (int t = 0; t < 30; t++) begin
            logic [3:0]  rp;
            int unsigned rl, rr, rg;
            rp = 4'($urandom);
            rl = $urandom_range(0, 7);
            rr = ($urandom_range(0, 5) == 0) ? 15 : $urandom_range(0, 3);
            rg = $urandom_range(0, 7);
            send(rp, rl, rr, rg, 1'b1);
        end

        repeat (3) @(posedge clock);
        #1;
        check("final_queue_empty", 32'(exp_q.size() + exp_busy_q.size()), 32'd0);
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
